// File: rtl/decode_pipe_unit_if.sv
// Fetch-to-execute bus of decode_pipe_unit: instruction handshake in, control bundle handshake out.
// The master side is the fetch/execute environment; the slave side is the decoder.
interface decode_pipe_unit_if #(
    parameter int RA_W   = 5,
    parameter int DATA_W = 32
);
    logic [31:0]       in_instr;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              resume;
    logic [RA_W-1:0]   reg1;
    logic [RA_W-1:0]   reg2;
    logic [RA_W-1:0]   reg3;
    logic [4:0]        s_r_amount;
    logic [DATA_W-1:0] im_data;
    logic [4:0]        alu_opcode;
    logic [1:0]        jump_mux_signal;
    logic              write_back_on_register_mux_signal;
    logic              alu_input_mux_signal;
    logic              register_write_word_enable;
    logic              register_write_byte_enable;
    logic              memwrite_enable_a;
    logic              memwrite_enable_b;
    logic              memread_enable_a;
    logic              memread_enable_b;
    logic              PC_enable;
    logic              halted;
    logic              illegal;

    modport master (
        output in_instr, in_valid, out_ready, resume,
        input  in_ready, out_valid, reg1, reg2, reg3, s_r_amount, im_data, alu_opcode,
               jump_mux_signal, write_back_on_register_mux_signal, alu_input_mux_signal,
               register_write_word_enable, register_write_byte_enable,
               memwrite_enable_a, memwrite_enable_b, memread_enable_a, memread_enable_b,
               PC_enable, halted, illegal
    );

    modport slave (
        input  in_instr, in_valid, out_ready, resume,
        output in_ready, out_valid, reg1, reg2, reg3, s_r_amount, im_data, alu_opcode,
               jump_mux_signal, write_back_on_register_mux_signal, alu_input_mux_signal,
               register_write_word_enable, register_write_byte_enable,
               memwrite_enable_a, memwrite_enable_b, memread_enable_a, memread_enable_b,
               PC_enable, halted, illegal
    );
endinterface

// File: rtl/decode_pipe_unit.sv
// Purpose: decodes 32-bit instructions into a registered control bundle, with HALT FSM and load-use interlock.
// Latency: 1 cycle from acceptance to out_valid; optional illegal-opcode trap via DECODE_ILLEGAL_TRAP_EN.
// Backpressure: bundle holds while out_valid && !out_ready; in_ready drops on HALT, hazard or a blocked bundle.
module decode_pipe_unit #(
    parameter int RA_W        = 5,
    parameter int DATA_W      = 32,
    parameter int LOAD_SHADOW = 1
) (
    input logic                clk,
    input logic                rst,
    decode_pipe_unit_if.slave  bus
);
    localparam int CNT_W = (LOAD_SHADOW > 1) ? $clog2(LOAD_SHADOW + 1) : 1;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [RA_W-1:0]   reg1;
        logic [RA_W-1:0]   reg2;
        logic [RA_W-1:0]   reg3;
        logic [4:0]        shamt;
        logic [DATA_W-1:0] imm;
        logic [4:0]        alu;
        logic [1:0]        jump;
        logic              wb;
        logic              alu_in;
        logic              rf_word;
        logic              rf_byte;
        logic              mw_a;
        logic              mw_b;
        logic              mr_a;
        logic              mr_b;
    } ctrl_t;

    state_t            state_q, state_d;
    ctrl_t             bundle_q, bundle_d, dec;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  haz_cnt_q, haz_cnt_d;
    logic [RA_W-1:0]   haz_reg_q, haz_reg_d;

    logic [5:0]        op;
    logic [DATA_W-1:0] imm_ext;
    logic              is_halt, is_load, is_trap;
    logic              run, hazard, in_ready, accept;

    assign op      = bus.in_instr[31:26];
    assign imm_ext = DATA_W'($signed(bus.in_instr[15:0]));

    always_comb begin
        dec     = '0;
        is_halt = 1'b0;
        is_load = 1'b0;
        is_trap = 1'b0;
        if (op == 6'd0) begin
            is_halt = 1'b1;
        end else if (op < 6'd16) begin
            dec.reg3    = RA_W'(bus.in_instr[25:21]);
            dec.reg1    = RA_W'(bus.in_instr[20:16]);
            dec.reg2    = RA_W'(bus.in_instr[15:11]);
            dec.shamt   = bus.in_instr[10:6];
            dec.alu     = {1'b0, op[3:0]};
            dec.rf_word = 1'b1;
            dec.wb      = 1'b1;
        end else if (op < 6'd24) begin
            dec.reg3    = RA_W'(bus.in_instr[25:21]);
            dec.reg1    = RA_W'(bus.in_instr[20:16]);
            dec.imm     = imm_ext;
            dec.rf_word = 1'b1;
            dec.wb      = 1'b1;
            dec.alu_in  = 1'b1;
            case (op[3:0])
                4'd2:    dec.alu = 5'd1;
                4'd3:    dec.alu = 5'd2;
                4'd4:    dec.alu = 5'd3;
                4'd5:    dec.alu = 5'd4;
                4'd6:    dec.alu = 5'd9;
                4'd7:    dec.alu = 5'd10;
                default: dec.alu = 5'd0;
            endcase
        end else if (op < 6'd28) begin
            // reg2 doubles as the store-data source and reg3 as the load destination
            dec.reg1   = RA_W'(bus.in_instr[20:16]);
            dec.reg2   = RA_W'(bus.in_instr[25:21]);
            dec.reg3   = RA_W'(bus.in_instr[25:21]);
            dec.imm    = imm_ext;
            dec.alu    = 5'd1;
            dec.alu_in = 1'b1;
            case (op[1:0])
                2'd0: begin dec.mr_a = 1'b1; dec.rf_word = 1'b1; is_load = 1'b1; end
                2'd1: dec.mw_a = 1'b1;
                2'd2: begin dec.mr_b = 1'b1; dec.rf_byte = 1'b1; is_load = 1'b1; end
                default: dec.mw_b = 1'b1;
            endcase
        end else if (op < 6'd32) begin
            dec.reg1 = RA_W'(bus.in_instr[25:21]);
            dec.reg2 = RA_W'(bus.in_instr[20:16]);
            dec.imm  = imm_ext;
            dec.wb   = 1'b1;
            case (op[1:0])
                2'd0: dec.jump = 2'd3;
                2'd1: dec.jump = 2'd2;
                2'd2: begin dec.jump = 2'd1; dec.alu = 5'd16; end
                default: begin dec.jump = 2'd1; dec.alu = 5'd15; end
            endcase
        end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            is_trap = 1'b1;
`endif
        end
    end

    assign run      = (state_q == RUN);
    assign hazard   = bus.in_valid && (haz_cnt_q != '0) && (haz_reg_q != '0) &&
                      ((dec.reg1 == haz_reg_q) || (dec.reg2 == haz_reg_q));
    assign in_ready = run && !hazard && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        haz_cnt_d   = haz_cnt_q;
        haz_reg_d   = haz_reg_q;
        illegal_d   = illegal_q | (accept && is_trap);

        if (run) begin
            if (accept && (is_halt || is_trap)) state_d = HALT;
        end else if (bus.resume && !illegal_q) begin
            state_d = RUN;
        end
        halted_d = (state_d == HALT);

        if (accept && !is_halt && !is_trap) begin
            bundle_d    = dec;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            bundle_d    = '0;
            out_valid_d = 1'b0;
        end

        // A stall cycle counts as an issue slot, otherwise the stalled reader could never drain the shadow
        if (accept && is_load) begin
            haz_cnt_d = CNT_W'(LOAD_SHADOW);
            haz_reg_d = dec.reg3;
        end else if ((accept || (run && hazard)) && (haz_cnt_q != '0)) begin
            haz_cnt_d = haz_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            haz_cnt_q   <= '0;
            haz_reg_q   <= '0;
        end else begin
            state_q     <= state_d;
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
            haz_cnt_q   <= haz_cnt_d;
            haz_reg_q   <= haz_reg_d;
        end
    end

    assign bus.in_ready                          = in_ready;
    assign bus.out_valid                         = out_valid_q;
    assign bus.PC_enable                         = run && !hazard;
    assign bus.halted                            = halted_q;
    assign bus.reg1                              = bundle_q.reg1;
    assign bus.reg2                              = bundle_q.reg2;
    assign bus.reg3                              = bundle_q.reg3;
    assign bus.s_r_amount                        = bundle_q.shamt;
    assign bus.im_data                           = bundle_q.imm;
    assign bus.alu_opcode                        = bundle_q.alu;
    assign bus.jump_mux_signal                   = bundle_q.jump;
    assign bus.write_back_on_register_mux_signal = bundle_q.wb;
    assign bus.alu_input_mux_signal              = bundle_q.alu_in;
    assign bus.register_write_word_enable        = bundle_q.rf_word;
    assign bus.register_write_byte_enable        = bundle_q.rf_byte;
    assign bus.memwrite_enable_a                 = bundle_q.mw_a;
    assign bus.memwrite_enable_b                 = bundle_q.mw_b;
    assign bus.memread_enable_a                  = bundle_q.mr_a;
    assign bus.memread_enable_b                  = bundle_q.mr_b;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign bus.illegal                           = illegal_q;
`else
    assign bus.illegal                           = 1'b0;
`endif
endmodule
